switch_debounce: RTL and testbench

Front-end conditioning stage for the four board switches/keys. It synchronises the raw pad inputs to HCLK, debounces each channel with its own counter, and drives `switch_data` into the AHB-Lite switch peripheral. It consumes that peripheral's `key_clear` pulse. With edge latching compiled in, software reads sticky press flags and clears them with a register write.

---
 rtl/switch_debounce.sv | 178 +++++++++++++++++
 tb/tb_switch_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce
// Conditions the four board switches/keys before they reach the AHB-Lite
// switch peripheral. Each pad is synchronised to HCLK through two flops.
// A small FSM with its own stability counter then debounces each channel.
//
// Optional build macro: SWITCH_EDGE_LATCH_EN
//   defined   - switch_data carries sticky rising-edge flags. A key_clear
//               strobe from the peripheral clears them.
//   undefined - switch_data is the debounced level and key_clear is ignored.
//
// Outputs are register outputs only. No combinational path runs from any
// input to switch_data or switch_level.

module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] switch_raw,
    input  logic       key_clear,
    output logic [3:0] switch_data,
    output logic [3:0] switch_level
);

    // Reject counter widths that could not hold DEBOUNCE_CYCLES-1, and
    // thresholds too small to leave a WAIT state meaning anything.
    generate
        if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
            $error("switch_debounce: DEBOUNCE_CYCLES must be in 2 .. 2**CNT_W-1");
        end
    endgenerate

    // Terminal count: the channel commits to a new level when its counter
    // holds this value and the synchronised input still disagrees with the
    // current level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [3:0] sync1;
    logic [3:0] sync0;
    logic [3:0] level;

    // Two-flop synchroniser for the asynchronous pads. Only sync0 is
    // consumed downstream; sync1 may go metastable and must not fan out.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync1 <= 4'h0;
            sync0 <= 4'h0;
        end else begin
            sync1 <= switch_raw;
            sync0 <= sync1;
        end
    end

`ifdef SWITCH_EDGE_LATCH_EN
    logic [3:0] rise;
`endif

    // Four identical, fully independent debounce channels.
    for (genvar i = 0; i < 4; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             lvl;
        logic             lvl_nxt;

        // Channel state, stability counter and debounced level register.
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
                state <= STABLE_LO;
                cnt   <= '0;
                lvl   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                lvl   <= lvl_nxt;
            end
        end

        // A WAIT state aborts on any disagreeing sample, so a pulse shorter
        // than DEBOUNCE_CYCLES at sync0 never reaches the level register.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            lvl_nxt   = lvl;
            case (state)
                STABLE_LO: begin
                    lvl_nxt = 1'b0;
                    cnt_nxt = '0;
                    if (sync0[i]) begin
                        state_nxt = WAIT_HI;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!sync0[i]) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        lvl_nxt   = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    lvl_nxt = 1'b1;
                    cnt_nxt = '0;
                    if (!sync0[i]) begin
                        state_nxt = WAIT_LO;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (sync0[i]) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        lvl_nxt   = 1'b0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    lvl_nxt   = 1'b0;
                end
            endcase
        end

        assign level[i] = lvl;

`ifdef SWITCH_EDGE_LATCH_EN
        // Rise is taken from the next-state value, so the flag sets on the
        // same edge that level goes high.
        assign rise[i] = ~lvl & lvl_nxt;
`endif
    end

`ifdef SWITCH_EDGE_LATCH_EN
    logic [3:0] flag;

    // Sticky press flags. When key_clear is sampled high, every flag not
    // being set on that edge is cleared. A set on the same edge wins, so a
    // press that lands with the clear is not lost.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            flag <= 4'h0;
        end else begin
            flag <= rise | (key_clear ? 4'h0 : flag);
        end
    end

    assign switch_data = flag;
`else
    // key_clear has no function in the level-only build.
    logic unused_key_clear;
    assign unused_key_clear = key_clear;

    assign switch_data = level;
`endif

    assign switch_level = level;

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4. Expected
// values are hand-computed edge counts from the point where the raw input
// changes. Covers both builds, selected by SWITCH_EDGE_LATCH_EN.

module tb_switch_debounce;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] switch_raw;
    logic       key_clear;
    logic [3:0] switch_data;
    logic [3:0] switch_level;

    int n_checks;
    int n_fails;

    switch_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .switch_raw  (switch_raw),
        .key_clear   (key_clear),
        .switch_data (switch_data),
        .switch_level(switch_level)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [3:0] actual,
                               input logic [3:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives both stimulus inputs together.
    task automatic applyStimulus(input logic [3:0] raw, input logic clr);
        switch_raw = raw;
        key_clear  = clr;
    endtask

    // Advances one rising edge and settles 1 time unit past it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Short reset pulse with all inputs idle.
    task automatic doReset();
        applyStimulus(4'h0, 1'b0);
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        HRESET     = 1'b1;
        switch_raw = 4'h0;
        key_clear  = 1'b0;
        tick();
        checkOutput("reset_data", switch_data, 4'h0);
        checkOutput("reset_level", switch_level, 4'h0);

        // Reset mid-count: reset lands 3 cycles after all switches go high.
        $display("[TB] reset mid-count");
        doReset();
        applyStimulus(4'hF, 1'b0);
        tick();
        tick();
        tick();
        HRESET = 1'b1;
        #1;
        checkOutput("midrst_data", switch_data, 4'h0);
        checkOutput("midrst_level", switch_level, 4'h0);
        tick();
        tick();
        checkOutput("midrst_hold_data", switch_data, 4'h0);
        checkOutput("midrst_hold_level", switch_level, 4'h0);
        HRESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("post_rst_level", switch_level, (k == 6) ? 4'hF : 4'h0);
            checkOutput("post_rst_data", switch_data, (k == 6) ? 4'hF : 4'h0);
        end

        // Glitch rejection: 3-cycle pulse on ch0 is discarded.
        $display("[TB] glitch rejection");
        doReset();
        applyStimulus(4'h1, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(4'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("short_pulse", switch_level, 4'h0);
        end

        // 5-cycle pulse on ch0: high after edge 6, low again after edge 11.
        applyStimulus(4'h1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 5) applyStimulus(4'h0, 1'b0);
            checkOutput("long_pulse", switch_level, (k >= 6 && k <= 10) ? 4'h1 : 4'h0);
        end

        // Bounce on ch2: 1-0-1-0-1 then held; one rise at edge 10.
        $display("[TB] bounce");
        doReset();
        begin
            logic [3:0] prev;
            int         rises;
            prev  = 4'h0;
            rises = 0;
            for (int k = 1; k <= 14; k++) begin
                if (k <= 5) applyStimulus(((k % 2) == 1) ? 4'h4 : 4'h0, 1'b0);
                tick();
                checkOutput("bounce_level", switch_level, (k >= 10) ? 4'h4 : 4'h0);
                if (!prev[2] && switch_level[2]) rises++;
                prev = switch_level;
            end
            checkOutput("bounce_rises", 4'(rises), 4'd1);
        end

`ifdef SWITCH_EDGE_LATCH_EN
        // Edge latch: two presses of ch1 with no clear leave one flag set.
        $display("[TB] edge latch");
        doReset();
        applyStimulus(4'h2, 1'b0);
        repeat (8) tick();
        checkOutput("press1_data", switch_data, 4'h2);
        applyStimulus(4'h0, 1'b0);
        repeat (8) tick();
        checkOutput("release_data", switch_data, 4'h2);
        checkOutput("release_level", switch_level, 4'h0);
        applyStimulus(4'h2, 1'b0);
        repeat (8) tick();
        checkOutput("press2_data", switch_data, 4'h2);
        checkOutput("press2_level", switch_level, 4'h2);
        applyStimulus(4'h2, 1'b1);
        tick();
        checkOutput("clear_data", switch_data, 4'h0);
        applyStimulus(4'h2, 1'b0);
        tick();
        checkOutput("after_clear_data", switch_data, 4'h0);

        // Collision: flag0 set, rise on ch3 coincides with key_clear.
        $display("[TB] set/clear collision");
        applyStimulus(4'h3, 1'b0);
        repeat (7) tick();
        checkOutput("flag0_data", switch_data, 4'h1);
        applyStimulus(4'hB, 1'b0);
        repeat (5) tick();
        checkOutput("pre_collide_data", switch_data, 4'h1);
        applyStimulus(4'hB, 1'b1);
        tick();
        checkOutput("collide_data", switch_data, 4'h8);
        checkOutput("collide_level", switch_level, 4'hB);
        applyStimulus(4'hB, 1'b0);
        tick();
        checkOutput("post_collide_data", switch_data, 4'h8);
`else
        // Level build: key_clear held high has no effect on either output.
        $display("[TB] key_clear ignored");
        doReset();
        applyStimulus(4'h5, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput("clr_hold_level_a", switch_level, (k >= 6) ? 4'h5 : 4'h0);
            checkOutput("clr_hold_data_a", switch_data, (k >= 6) ? 4'h5 : 4'h0);
        end
        applyStimulus(4'h3, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput("clr_hold_level_b", switch_level, (k >= 6) ? 4'h3 : 4'h5);
            checkOutput("clr_hold_data_b", switch_data, (k >= 6) ? 4'h3 : 4'h5);
        end
        applyStimulus(4'h3, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
